// File: rtl/ahb_sram_pkg.sv
// Shared AHB encodings, FSM state constants and lane helpers for the AHB SRAM slave.
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_WAIT = 3'd1;
  localparam state_t ST_DATA = 3'd2;
  localparam state_t ST_ERR1 = 3'd3;
  localparam state_t ST_ERR2 = 3'd4;

  function automatic logic trans_active(input logic [1:0] htrans);
    case (htrans)
      HTRANS_IDLE, HTRANS_BUSY: trans_active = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
      default: trans_active = 1'b0;
    endcase
  endfunction

  // Lane mask for a size, unshifted; sizes beyond 8 bytes are rejected elsewhere.
  function automatic logic [7:0] size_lanes(input logic [2:0] hsize);
    case (hsize)
      HSIZE_BYTE:  size_lanes = 8'h01;
      HSIZE_HALF:  size_lanes = 8'h03;
      HSIZE_WORD:  size_lanes = 8'h0F;
      HSIZE_DWORD: size_lanes = 8'hFF;
      default:     size_lanes = 8'hFF;
    endcase
  endfunction

  function automatic logic [2:0] align_mask(input logic [2:0] hsize);
    case (hsize)
      HSIZE_BYTE: align_mask = 3'b000;
      HSIZE_HALF: align_mask = 3'b001;
      HSIZE_WORD: align_mask = 3'b011;
      default:    align_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Byte-enable synchronous RAM, one write port and one registered read port.
module ahb_sram_array #(
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 1024,
  localparam int NB       = DATA_W / 8,
  localparam int AW       = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [NB-1:0]     wbe,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Read-before-write: a same-edge read returns the old word.
  always_comb rdata_d = re ? mem[raddr] : rdata_q;

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    for (int i = 0; i < NB; i++) begin
      if (we && wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: protocol FSM, error detection, write/read forwarding.
// Optional wait-state insertion is enabled by defining AHB_SRAM_WAIT_STATES_EN.
module ahb_sram_slave
  import ahb_sram_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int NB  = DATA_W / 8;
  localparam int LSB = $clog2(NB);
  localparam int AW  = $clog2(MEM_WORDS);

  state_t            state_q, state_d;
  logic              wr_q, wr_d, rd_q, rd_d, fwd_q, fwd_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [NB-1:0]     be_q, be_d, fwd_be_q, fwd_be_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d, hrdata_q, hrdata_d;
  logic [DATA_W-1:0] ram_rdata, merged;

  logic              cap, cap_err, cap_ok, ram_we;
  logic [AW-1:0]     haddr_word;
  logic [NB-1:0]     cap_be;

`ifdef AHB_SRAM_WAIT_STATES_EN
  logic [2:0] cnt_q, cnt_d;
`else
  logic unused_ws;
  assign unused_ws = (WAIT_STATES != 0);
`endif

  logic unused_haddr;
  assign unused_haddr = ^HADDR[31:LSB+AW];

  assign haddr_word = HADDR[LSB +: AW];
  assign cap        = HSEL & HREADY & trans_active(HTRANS);
  assign cap_err    = (HSIZE > 3'(LSB)) | ((HADDR[2:0] & align_mask(HSIZE)) != 3'b000);
  assign cap_ok     = cap & ~cap_err;
  assign cap_be     = NB'(size_lanes(HSIZE) << HADDR[LSB-1:0]);
  assign ram_we     = (state_q == ST_DATA) & wr_q;

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    fwd_d      = fwd_q;
    addr_d     = addr_q;
    be_d       = be_q;
    fwd_be_d   = fwd_be_q;
    fwd_data_d = fwd_data_q;
`ifdef AHB_SRAM_WAIT_STATES_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
`ifdef AHB_SRAM_WAIT_STATES_EN
      ST_WAIT: begin
        if (cnt_q == 3'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 3'd1;
      end
`endif
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all end a data phase and may take the next address phase.
        wr_d  = cap_ok & HWRITE;
        rd_d  = cap_ok & ~HWRITE;
        fwd_d = cap_ok & ~HWRITE & ram_we & (addr_q == haddr_word);
        if (cap) begin
          addr_d     = haddr_word;
          be_d       = cap_be;
          fwd_be_d   = be_q;
          fwd_data_d = HWDATA;
          if (cap_err) begin
            state_d = ST_ERR1;
          end else begin
`ifdef AHB_SRAM_WAIT_STATES_EN
            if (WAIT_STATES > 0) begin
              state_d = ST_WAIT;
              cnt_d   = 3'(WAIT_STATES - 1);
            end else begin
              state_d = ST_DATA;
            end
`else
            state_d = ST_DATA;
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // A read that raced a same-word write sees the freshly written lanes.
  always_comb begin
    merged = ram_rdata;
    for (int i = 0; i < NB; i++) begin
      if (fwd_q && fwd_be_q[i]) merged[i*8 +: 8] = fwd_data_q[i*8 +: 8];
    end
  end

  assign hrdata_d = ((state_q == ST_DATA) && rd_q) ? merged : hrdata_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      fwd_q    <= 1'b0;
      hrdata_q <= '0;
`ifdef AHB_SRAM_WAIT_STATES_EN
      cnt_q    <= 3'd0;
`endif
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      fwd_q    <= fwd_d;
      hrdata_q <= hrdata_d;
`ifdef AHB_SRAM_WAIT_STATES_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_ff @(posedge HCLK) begin
    addr_q     <= addr_d;
    be_q       <= be_d;
    fwd_be_q   <= fwd_be_d;
    fwd_data_q <= fwd_data_d;
  end

  ahb_sram_array #(
    .DATA_W   (DATA_W),
    .MEM_WORDS(MEM_WORDS)
  ) u_array (
    .clk  (HCLK),
    .we   (ram_we),
    .waddr(addr_q),
    .wbe  (be_q),
    .wdata(HWDATA),
    .re   (cap_ok & ~HWRITE),
    .raddr(haddr_word),
    .rdata(ram_rdata)
  );

  assign HRDATA    = hrdata_d;
  assign HREADYOUT = ~((state_q == ST_WAIT) | (state_q == ST_ERR1));
  assign HRESP     = ((state_q == ST_ERR1) | (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: byte-level memory model, randomized AHB traffic.
module tb_ahb_sram_slave;

  localparam int DW        = 32;
  localparam int MW        = 64;
  localparam int WS        = 3;
  localparam int MEM_BYTES = MW * 4;
`ifdef AHB_SRAM_WAIT_STATES_EN
  localparam int WS_EXP = WS;
`else
  localparam int WS_EXP = 0;
`endif

  logic          HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HWRITE = 1'b0;
  logic [31:0]   HADDR = '0;
  logic [1:0]    HTRANS = 2'b00;
  logic [2:0]    HSIZE = 3'd0;
  logic [DW-1:0] HWDATA = '0;
  logic [DW-1:0] HRDATA;
  logic          HREADYOUT, HRESP, HREADY;

  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  ahb_sram_slave #(.DATA_W(DW), .MEM_WORDS(MW), .WAIT_STATES(WS)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  typedef struct {
    bit          rd;
    bit          err;
    logic [31:0] data;
    int          waits;
    int          id;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem_m [MEM_BYTES];
  int         checks = 0, passed = 0, tid = 0;

  function automatic void check(input string nm, input int id, input logic [31:0] act,
                                input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s (xfer %0d): got %h expected %h", nm, id, act, expv);
  endfunction

  // Expected response derived from AHB rules; memory model updated in issue order.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [2:0] sz,
                       input logic [31:0] wd, input bit sel);
    exp_t e;
    int   off, wb, n;
    off = int'(addr % MEM_BYTES);
    wb  = off & ~3;
    if (sel) begin
      e.rd    = !wr;
      e.err   = (sz > 3'd2) || ((off % (1 << sz)) != 0);
      e.waits = e.err ? 1 : WS_EXP;
      e.data  = {mem_m[wb+3], mem_m[wb+2], mem_m[wb+1], mem_m[wb]};
      e.id    = tid++;
      if (!e.err && wr)
        for (int i = 0; i < (1 << sz); i++) mem_m[off+i] = wd[((off+i)%4)*8 +: 8];
      exp_q.push_back(e);
    end
    HSEL   = sel;
    HTRANS = ($urandom % 2) ? 2'b10 : 2'b11;
    HADDR  = addr;
    HWRITE = wr;
    HSIZE  = sz;
    n = 0;
    @(negedge HCLK);
    while (!HREADYOUT && n < 50) begin
      n++;
      @(negedge HCLK);
    end
    if (n >= 50) check("accept_timeout", tid, 32'(n), 32'd0);
    @(posedge HCLK);
    #1;
    HWDATA = wd;
    HTRANS = 2'b00;
    HSEL   = 1'b0;
  endtask

  task automatic idle(input int n);
    HTRANS = 2'b00;
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // Monitor: follows data phases from bus signals and scores each completion.
  bit active = 0, wbad = 0;
  int wcnt = 0;
  always @(negedge HCLK) begin
    exp_t e;
    if (!HRESETn) begin
      active = 0;
      exp_q.delete();
    end else begin
      if (active) begin
        if (!HREADYOUT) begin
          wcnt++;
          if (exp_q.size() > 0 && HRESP !== exp_q[0].err) wbad = 1;
        end else if (exp_q.size() == 0) begin
          check("unexpected_completion", -1, 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("hresp", e.id, 32'(HRESP), 32'(e.err));
          check("wait_cycles", e.id, 32'(wcnt), 32'(e.waits));
          if (e.waits > 0) check("wait_hresp", e.id, 32'(wbad), 32'd0);
          if (e.rd && !e.err) check("hrdata", e.id, HRDATA, e.data);
        end
      end
      if (!(active && !HREADYOUT)) begin
        active = HSEL && HREADYOUT && HTRANS[1];
        wcnt   = 0;
        wbad   = 0;
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    logic [7:0]  saved [4];
    logic [2:0]  sz;
    int          n;

    #2;
    check("reset_hreadyout", -1, 32'(HREADYOUT), 32'd1);
    check("reset_hresp", -1, 32'(HRESP), 32'd0);
    check("reset_hrdata", -1, HRDATA, 32'd0);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    issue(1, 32'h010, 3'd2, 32'hDEADBEEF, 1); idle(2);
    issue(0, 32'h010, 3'd2, 32'h0, 1);        idle(2);
    issue(1, 32'h020, 3'd2, 32'h00000000, 1);
    issue(1, 32'h022, 3'd0, 32'hCCAABBDD, 1);
    issue(0, 32'h020, 3'd2, 32'h0, 1);        idle(1);
    issue(1, 32'h040, 3'd2, 32'h12345678, 1);
    issue(0, 32'h040, 3'd2, 32'h0, 1);        idle(1);
    issue(1, 32'h000, 3'd2, 32'hA5A5A5A5, 1);
    issue(1, 32'h001, 3'd1, 32'hFFFFFFFF, 1);
    issue(1, 32'h000, 3'd3, 32'h00000000, 1);
    issue(1, 32'h002, 3'd2, 32'h11111111, 1);
    issue(0, 32'h000, 3'd2, 32'h0, 1);
    issue(1, 32'h000, 3'd2, 32'h77777777, 0);
    issue(0, 32'hFFFF_F100, 3'd2, 32'h0, 1);  idle(2);

    // Reset in the first cycle of a write data phase: write must be dropped.
    issue(1, 32'h080, 3'd2, 32'h11111111, 1);
    issue(0, 32'h080, 3'd2, 32'h0, 1);        idle(2);
    for (int i = 0; i < 4; i++) saved[i] = mem_m[128+i];
    issue(1, 32'h080, 3'd2, 32'h22222222, 1);
    HRESETn = 1'b0;
    #1;
    check("rst_mid_hreadyout", -1, 32'(HREADYOUT), 32'd1);
    check("rst_mid_hresp", -1, 32'(HRESP), 32'd0);
    check("rst_mid_hrdata", -1, HRDATA, 32'd0);
    for (int i = 0; i < 4; i++) mem_m[128+i] = saved[i];
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    issue(0, 32'h080, 3'd2, 32'h0, 1);        idle(2);

    for (int w = 0; w < MW; w++) issue(1, 32'(w * 4), 3'd2, $urandom, 1);
    for (int k = 0; k < 250; k++) begin
      sz = ($urandom % 10 == 0) ? 3'd3 : 3'($urandom % 3);
      a  = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 255));
      if ($urandom % 8 != 0) a = a & ~((32'd1 << sz) - 32'd1);
      d  = $urandom;
      issue($urandom % 2, a, sz, d, ($urandom % 12) != 0);
      if ($urandom % 4 == 0) idle($urandom % 3);
    end
    idle(4);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(posedge HCLK);
    end
    #1;
    check("scoreboard_drained", -1, 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: data bus width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter MEM_WORDS, default 1024: memory depth in DATA_W words; power of two.
REQ-003 The block SHALL have parameter WAIT_STATES, default 1: wait cycles inserted per OKAY transfer; range 0..7.
REQ-004 The block SHALL have port HCLK, input, 1 bit: clock; all logic on the rising edge.
REQ-005 The block SHALL have port HRESETn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port HSEL, input, 1 bit: decoder select.
REQ-007 The block SHALL have port HADDR, input, 32 bits: byte address.
REQ-008 The block SHALL have port HTRANS, input, 2 bits: IDLE/BUSY/NONSEQ/SEQ.
REQ-009 The block SHALL have port HWRITE, input, 1 bit: 1 = write.
REQ-010 The block SHALL have port HSIZE, input, 3 bits: transfer size, log2 of bytes.
REQ-011 The block SHALL have port HWDATA, input, DATA_W bits: write data, valid in the data phase.
REQ-012 The block SHALL have port HREADY, input, 1 bit: bus-wide ready.
REQ-013 The block SHALL have port HRDATA, output, DATA_W bits: read data.
REQ-014 The block SHALL have port HREADYOUT, output, 1 bit: slave ready.
REQ-015 The block SHALL have port HRESP, output, 1 bit: 0 = OKAY, 1 = ERROR.

Function
REQ-016 The block SHALL capture an address phase only on a rising edge with HSEL=1, HREADY=1 and HTRANS[1]=1 (NONSEQ or SEQ).
- IDLE, BUSY or HSEL=0 transfers SHALL get a zero-wait OKAY response.
REQ-017 The block SHALL treat address offset = HADDR modulo (MEM_WORDS*DATA_W/8).
- The upper HADDR bits SHALL be ignored; decode belongs to the decoder.
REQ-018 The block SHALL respond ERROR when the captured HSIZE > log2(DATA_W/8), or when HADDR is not aligned to HSIZE.
REQ-019 The block SHALL give every ERROR response as two cycles:
- cycle 1: HREADYOUT=0, HRESP=1
- cycle 2: HREADYOUT=1, HRESP=1
- no memory write occurs.
REQ-020 The block SHALL give an OKAY transfer WAIT_STATES cycles of HREADYOUT=0, HRESP=0, then one cycle of HREADYOUT=1, HRESP=0.
REQ-021 The block SHALL derive write byte enables from HSIZE and HADDR low bits and write only those lanes.
- Data SHALL be taken from the matching HWDATA lanes (no shifting).
- The write SHALL commit at the edge that ends the data phase.
REQ-022 The block SHALL return read data as the full addressed word on HRDATA, lane-aligned and not shifted or zero-extended.
- HRDATA SHALL be valid while HREADYOUT=1 in the data phase.
REQ-023 The block SHALL forward merged write data when a read's address phase coincides with the commit edge of a write to the same word, so HRDATA reflects the new bytes.
REQ-024 The block SHALL accept a new address phase on the same edge that completes the previous data phase, giving back-to-back pipelining with no idle cycle.
REQ-025 The block SHALL implement the FSM states IDLE, WAIT, DATA, ERR1, ERR2.
- IDLE→WAIT on an OKAY capture when WAIT_STATES>0.
- IDLE→DATA on an OKAY capture when WAIT_STATES=0.
- IDLE→ERR1 on an error capture.
- WAIT→DATA when the wait counter reaches 0.
- ERR1→ERR2 unconditionally.
- DATA/ERR2→IDLE, or straight into the next phase when a new transfer is captured.
REQ-026 The block SHALL keep HRDATA at its last value outside read data phases.

Reset
REQ-027 On HRESETn=0 the block SHALL force state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0 and wait counter 0, and SHALL abandon any pending transfer without writing memory.
REQ-028 The block SHALL NOT reset memory contents; they are undefined after power-up.

Configuration
REQ-029 With AHB_SRAM_WAIT_STATES_EN defined, the block SHALL insert WAIT_STATES cycles per REQ-020.
REQ-030 Without AHB_SRAM_WAIT_STATES_EN, the block SHALL ignore WAIT_STATES, omit the WAIT state and counter logic, and complete every OKAY transfer with zero wait.

Structure
REQ-031 Package ahb_sram_pkg SHALL hold the HTRANS, HRESP and HSIZE encodings and the FSM state type.
REQ-032 Sub-module ahb_sram_array SHALL implement the byte-enable synchronous RAM: one write port, one read port, MEM_WORDS x DATA_W.
- All protocol logic SHALL stay in ahb_sram_slave.

Verification
REQ-033 Word write 0xDEADBEEF to 0x010, then word read 0x010 (WAIT_STATES=0) → HRDATA=0xDEADBEEF, HRESP=0, no wait cycles.
REQ-034 Word write 0x00000000 to 0x020, byte write 0xAA to 0x022, word read 0x020 → HRDATA=0x00AA0000.
REQ-035 Word write 0x12345678 to 0x040 immediately followed by a read of 0x040 → HRDATA=0x12345678 (forwarding).
REQ-036 Halfword access to 0x001, and word access with HSIZE=3 on DATA_W=32 → two-cycle ERROR per REQ-019; a following read shows memory unchanged.
REQ-037 With the macro defined and WAIT_STATES=3, word read → exactly 3 cycles HREADYOUT=0, then data with OKAY; without the macro → 0 wait cycles.
REQ-038 HRESETn asserted during a WAIT cycle of a write → outputs at reset values immediately, and a later read shows the old data.
